// File: rtl/fft_stage_addr_generator.sv
// rtl/fft_stage_addr_generator.sv - read address / twiddle index sequencer for FFT stages 1..SIZE-1
module fft_stage_addr_generator #(
  parameter int N    = 16,
  parameter int SIZE = 4,
  parameter int LAT  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_stage,
  output logic            en_rd,
  output logic [SIZE-1:0] rd_ptr,
  output logic [10:0]     rd_ptr_angle,
  output logic [3:0]      stage_num,
  output logic            busy,
  output logic            fft_done
);

  localparam logic [3:0]      LAST_STAGE = 4'(SIZE - 1);
  localparam logic [SIZE-1:0] LAST_PAIR  = SIZE'(N / 2 - 1);
  localparam logic [3:0]      DRAIN_INIT = 4'(LAT - 1);

  typedef enum logic [2:0] {IDLE, READ_1, READ_2, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      stage_q, stage_d;      // doubles as stage_num: 0 outside a run
  logic [SIZE-1:0] pair_q, pair_d;        // butterfly index within the stage, k fastest
  logic [3:0]      drain_q, drain_d;
  logic            en_rd_q, en_rd_d;
  logic [SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [10:0]     angle_q, angle_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [SIZE-1:0] next_pair;

  // Low s bits select k within a group of half-span 2^s.
  function automatic logic [SIZE-1:0] lo_mask(input logic [3:0] s);
    return (SIZE'(1) << s) - SIZE'(1);
  endfunction

  // top = g*2h + k, with g = pair >> s and k = pair & (h-1).
  function automatic logic [SIZE-1:0] top_of(input logic [3:0] s, input logic [SIZE-1:0] p);
    return ((p >> s) << (s + 4'd1)) | (p & lo_mask(s));
  endfunction

  // angle = k * N / (2h) = k << (SIZE-1-s).
  function automatic logic [10:0] angle_of(input logic [3:0] s, input logic [SIZE-1:0] p);
    logic [10:0] k;
    k = 11'(p & lo_mask(s));
    return k << (LAST_STAGE - s);
  endfunction

  assign next_pair = pair_q + SIZE'(1);

  // Next-state and registered-output computation; outputs hold unless a state updates them.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    drain_d = drain_q;
    en_rd_d = 1'b0;
    rd_ptr_d = rd_ptr_q;
    angle_d = angle_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stage) begin
          state_d  = READ_1;
          stage_d  = 4'd1;
          pair_d   = '0;
          en_rd_d  = 1'b1;
          rd_ptr_d = '0;
          angle_d  = '0;
          busy_d   = 1'b1;
        end
      end
      READ_1: begin
        state_d  = READ_2;
        en_rd_d  = 1'b1;
        rd_ptr_d = rd_ptr_q + (SIZE'(1) << stage_q);
      end
      READ_2: begin
        if (pair_q == LAST_PAIR) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          state_d  = READ_1;
          pair_d   = next_pair;
          en_rd_d  = 1'b1;
          rd_ptr_d = top_of(stage_q, next_pair);
          angle_d  = angle_of(stage_q, next_pair);
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) begin
          if (stage_q == LAST_STAGE) begin
            state_d = DONE;
            stage_d = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = READ_1;
            stage_d  = stage_q + 4'd1;
            pair_d   = '0;
            en_rd_d  = 1'b1;
            rd_ptr_d = '0;
            angle_d  = '0;
          end
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stage_q  <= 4'd0;
      pair_q   <= '0;
      drain_q  <= 4'd0;
      en_rd_q  <= 1'b0;
      rd_ptr_q <= '0;
      angle_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      pair_q   <= pair_d;
      drain_q  <= drain_d;
      en_rd_q  <= en_rd_d;
      rd_ptr_q <= rd_ptr_d;
      angle_q  <= angle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign en_rd        = en_rd_q;
  assign rd_ptr       = rd_ptr_q;
  assign rd_ptr_angle = angle_q;
  assign stage_num    = stage_q;
  assign busy         = busy_q;
  assign fft_done     = done_q;

endmodule

// File: doc/fft_stage_addr_generator.md
FFT_STAGE_ADDR_GENERATOR -- requirements
Module: fft_stage_addr_generator

Interface
REQ-001 SHALL have parameter N, default 16, FFT length (power of two, 4..2048).
REQ-002 SHALL have parameter SIZE, default 4, log2(N).
REQ-003 SHALL have parameter LAT, default 4, drain cycles after each stage (butterfly pipeline flush); range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_stage  input  1  one-cycle start pulse from the first-stage address generator's start_next_stage.
REQ-007 SHALL have port en_rd  output  1  read enable to the data memory.
REQ-008 SHALL have port rd_ptr  output  SIZE  read address.
REQ-009 SHALL have port rd_ptr_angle  output  11  twiddle index, in units of 2*pi/N.
REQ-010 SHALL have port stage_num  output  4  current stage, 1..SIZE-1; 0 when idle.
REQ-011 SHALL have port busy  output  1  high from the first read cycle through the last drain cycle.
REQ-012 SHALL have port fft_done  output  1  one-cycle pulse after the final stage drains.

Function
REQ-013 SHALL implement FSM states IDLE, READ_1, READ_2, DRAIN, DONE; all outputs registered.
REQ-014 SHALL process stages s = 1..SIZE-1 in order after one start; stage 0 is produced upstream.
REQ-015 SHALL use, per stage s: half-span h = 2^s; group g = 0..N/(2h)-1; index k = 0..h-1; top = g*2h + k; bottom = top + h.
REQ-016 SHALL, in READ_1, drive en_rd=1, rd_ptr=top, rd_ptr_angle = k*N/(2h), zero-extended to 11 bits.
REQ-017 SHALL, in READ_2, drive en_rd=1, rd_ptr=bottom, with rd_ptr_angle held from READ_1.
REQ-018 SHALL iterate k fastest, then g; each stage is exactly N en_rd-high cycles with no gaps.
REQ-019 SHALL compute all address arithmetic modulo 2^SIZE; no ptr exceeds N-1.
REQ-020 SHALL, after the final READ_2 of a stage, enter DRAIN for exactly LAT cycles with en_rd=0, rd_ptr and rd_ptr_angle held.
REQ-021 SHALL, at DRAIN exit, start stage s+1 at READ_1 if s < SIZE-1; otherwise go to DONE.
REQ-022 SHALL hold DONE one cycle with fft_done=1, busy=0, stage_num=0, then return to IDLE.
REQ-023 SHALL, in IDLE with start_stage=1 sampled at edge t, present en_rd=1, rd_ptr=0, stage_num=1 in cycle t+1.
REQ-024 SHALL ignore start_stage while busy=1 or in DONE; no restart, no counter disturbance.
REQ-025 SHALL support a start_stage in the cycle after fft_done, beginning a new run.
REQ-026 SHALL require SIZE <= 11; N != 2^SIZE is unsupported.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force IDLE, en_rd=0, rd_ptr=0, rd_ptr_angle=0, stage_num=0, busy=0, fft_done=0, and clear all counters.
REQ-028 SHALL, on rst_n asserted mid-stage or mid-drain, abandon the run; after release, remain in IDLE until a new start_stage.

Verification
REQ-029 SHALL cover: N=16, LAT=4, start at cycle 0 -> stage1 en_rd cycles 1..16, rd_ptr 0,2,1,3,4,6,5,7,8,10,9,11,12,14,13,15, angles 0,0,4,4 repeating.
REQ-030 SHALL cover: same run -> stage2 reads in cycles 21..36 (0,4,1,5,2,6,3,7,...), angles 0,2,4,6; stage3 reads in cycles 41..56 (0,8,1,9,...,7,15), angles 0..7; fft_done only in cycle 61.
REQ-031 SHALL cover: start_stage pulses at cycles 10 and 45 of a run -> trace identical to REQ-029/030.
REQ-032 SHALL cover: rst_n low at cycle 30 for 2 cycles -> all outputs 0 immediately; idle until the next start, then the full REQ-029 sequence.
REQ-033 SHALL cover: N=4, SIZE=2, LAT=1 -> one stage, reads 0,2,1,3 with angles 0,0,1,1 in cycles 1..4; drain in cycle 5; fft_done in cycle 6.
REQ-034 SHALL cover: back-to-back start in the cycle after fft_done -> second run starts with rd_ptr=0, no lost cycle.
